// File: rtl/bridge_pkg.sv
// Shared definitions for the CPU write-side bridge: slot indices, address map, FSM states.
package bridge_pkg;

  localparam int NUM_SLOTS = 4;

  typedef enum logic [1:0] {
    SLOT_DM   = 2'd0,
    SLOT_TMR0 = 2'd1,
    SLOT_TMR1 = 2'd2,
    SLOT_OUT  = 2'd3
  } slot_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Inclusive byte-address windows.
  localparam logic [31:0] DM_BASE    = 32'h0000_0000;
  localparam logic [31:0] DM_LIMIT   = 32'h0000_2FFF;
  localparam logic [31:0] TMR0_BASE  = 32'h0000_7F00;
  localparam logic [31:0] TMR0_LIMIT = 32'h0000_7F0B;
  localparam logic [31:0] TMR1_BASE  = 32'h0000_7F10;
  localparam logic [31:0] TMR1_LIMIT = 32'h0000_7F1B;
  localparam logic [31:0] OUT_BASE   = 32'h0000_7F20;
  localparam logic [31:0] OUT_LIMIT  = 32'h0000_7F23;

endpackage

// File: rtl/bridge_addr_decode.sv
// Store address decoder: slot hit, slot index and slot-relative offset.
// Purely combinational, no backpressure.
module bridge_addr_decode
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 14
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output slot_e             slot,
  output logic [OFF_W-1:0]  off
);

  logic [ADDR_W-1:0] base;

  function automatic logic in_rng(input logic [ADDR_W-1:0] a,
                                  input logic [31:0]       lo,
                                  input logic [31:0]       hi);
    return (a >= ADDR_W'(lo)) && (a <= ADDR_W'(hi));
  endfunction

  always_comb begin
    hit  = 1'b1;
    slot = SLOT_DM;
    base = '0;
    if (in_rng(addr, DM_BASE, DM_LIMIT)) begin
      slot = SLOT_DM;
      base = ADDR_W'(DM_BASE);
    end else if (in_rng(addr, TMR0_BASE, TMR0_LIMIT)) begin
      slot = SLOT_TMR0;
      base = ADDR_W'(TMR0_BASE);
    end else if (in_rng(addr, TMR1_BASE, TMR1_LIMIT)) begin
      slot = SLOT_TMR1;
      base = ADDR_W'(TMR1_BASE);
    end else if (in_rng(addr, OUT_BASE, OUT_LIMIT)) begin
      slot = SLOT_OUT;
      base = ADDR_W'(OUT_BASE);
    end else begin
      hit = 1'b0;
    end
  end

  assign off = OFF_W'(addr - base);

endmodule

// File: rtl/bridge_wr_demux.sv
// Routes one CPU store to one of four write slots via a one-entry holding register.
// Latency 1 cycle accept-to-strobe; req_ready low while the held slot is not ready.
module bridge_wr_demux
  import bridge_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int OFF_W  = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [3:0]           req_be,
  output logic                 req_ready,
  output logic [NUM_SLOTS-1:0] slot_wen,
  output logic [OFF_W-1:0]     slot_off,
  output logic [DATA_W-1:0]    slot_wdata,
  output logic [3:0]           slot_be,
  input  logic [NUM_SLOTS-1:0] slot_ready,
  output logic                 err_valid,
  output logic [ADDR_W-1:0]    err_addr
);

  state_e           state;
  slot_e            sel;
  logic             dec_hit;
  slot_e            dec_slot;
  logic [OFF_W-1:0] dec_off;
  logic             done;
  logic             accept;

  bridge_addr_decode #(
    .ADDR_W(ADDR_W),
    .OFF_W (OFF_W)
  ) u_dec (
    .addr(req_addr),
    .hit (dec_hit),
    .slot(dec_slot),
    .off (dec_off)
  );

  assign done      = (state == HOLD) && slot_ready[sel];
  // Completing cycle also accepts, so a always-ready slot sees one store per cycle.
  assign req_ready = !reset && ((state == IDLE) || done);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel        <= SLOT_DM;
      slot_wen   <= '0;
      slot_off   <= '0;
      slot_wdata <= '0;
      slot_be    <= '0;
      err_valid  <= 1'b0;
      err_addr   <= '0;
    end else begin
      err_valid <= 1'b0;
      if (done) begin
        state    <= IDLE;
        slot_wen <= '0;
      end
      // Zero byte-enable stores are swallowed, even when unmapped.
      if (accept && (req_be != 4'd0)) begin
        if (dec_hit) begin
          state      <= HOLD;
          sel        <= dec_slot;
          slot_wen   <= NUM_SLOTS'(1) << dec_slot;
          slot_off   <= dec_off;
          slot_wdata <= req_wdata;
          slot_be    <= req_be;
        end else begin
          err_valid <= 1'b1;
          err_addr  <= req_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_bridge_wr_demux.sv
// Bench for bridge_wr_demux: directed vector table, reset-in-HOLD sequence, random vs. model.
module tb_bridge_wr_demux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready;
  logic [3:0]  slot_wen;
  logic [13:0] slot_off;
  logic [31:0] slot_wdata;
  logic [3:0]  slot_be;
  logic [3:0]  slot_ready = '0;
  logic        err_valid;
  logic [31:0] err_addr;

  int compared = 0;
  int mismatched = 0;

  bridge_wr_demux dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .req_ready (req_ready),
    .slot_wen  (slot_wen),
    .slot_off  (slot_off),
    .slot_wdata(slot_wdata),
    .slot_be   (slot_be),
    .slot_ready(slot_ready),
    .err_valid (err_valid),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One row = one clock cycle: inputs driven this cycle, outputs expected this cycle.
  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  ready;
    logic [3:0]  exp_wen;
    logic [31:0] exp_off;
    logic        exp_rdy;
    logic        exp_err;
    logic [31:0] exp_eaddr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic v, logic [31:0] a, logic [3:0] be, logic [3:0] rdy,
                              logic [3:0] wen, logic [31:0] off, logic er, logic e, logic [31:0] ea);
    vec_t r;
    r.valid = v; r.addr = a; r.wdata = a ^ 32'hDEADBEEF; r.be = be; r.ready = rdy;
    r.exp_wen = wen; r.exp_off = off; r.exp_rdy = er; r.exp_err = e; r.exp_eaddr = ea;
    return r;
  endfunction

  // Address-map reference for the random phase.
  logic [31:0] map_lo[4] = '{32'h0000_0000, 32'h0000_7F00, 32'h0000_7F10, 32'h0000_7F20};
  logic [31:0] map_hi[4] = '{32'h0000_2FFF, 32'h0000_7F0B, 32'h0000_7F1B, 32'h0000_7F23};
  logic [31:0] miss_list[6] = '{32'h0000_3000, 32'h0000_7EFF, 32'h0000_7F0C,
                                32'h0000_7F1C, 32'h0000_7F24, 32'hFFFF_FFFF};

  initial begin
    // Model state: the pending store, if any, and the error record.
    bit          pv;
    int          ps;
    logic [31:0] poff;
    logic [31:0] pdata;
    logic [3:0]  pbe;
    bit          eflag;
    logic [31:0] eaddr;

    tv.push_back(mk(1, 32'h0000_1004, 4'hF, 4'hF, 4'b0000, 0,          1, 0, 0));
    tv.push_back(mk(0, 0,             4'h0, 4'h1, 4'b0001, 32'h1004,   1, 0, 0));
    tv.push_back(mk(0, 0,             4'h0, 4'h1, 4'b0000, 0,          1, 0, 0));
    tv.push_back(mk(1, 32'h0000_7F14, 4'h3, 4'h0, 4'b0000, 0,          1, 0, 0));
    tv.push_back(mk(0, 0,             4'h0, 4'hB, 4'b0100, 32'h4,      0, 0, 0));
    tv.push_back(mk(0, 0,             4'h0, 4'hB, 4'b0100, 32'h4,      0, 0, 0));
    tv.push_back(mk(0, 0,             4'h0, 4'hB, 4'b0100, 32'h4,      0, 0, 0));
    tv.push_back(mk(0, 0,             4'h0, 4'h4, 4'b0100, 32'h4,      1, 0, 0));
    tv.push_back(mk(0, 0,             4'h0, 4'hF, 4'b0000, 0,          1, 0, 0));
    tv.push_back(mk(1, 32'h0000_7F00, 4'hF, 4'hF, 4'b0000, 0,          1, 0, 0));
    tv.push_back(mk(1, 32'h0000_7F20, 4'hF, 4'hF, 4'b0010, 0,          1, 0, 0));
    tv.push_back(mk(1, 32'h0000_0008, 4'hF, 4'hF, 4'b1000, 0,          1, 0, 0));
    tv.push_back(mk(0, 0,             4'h0, 4'hF, 4'b0001, 32'h8,      1, 0, 0));
    tv.push_back(mk(0, 0,             4'h0, 4'hF, 4'b0000, 0,          1, 0, 0));
    tv.push_back(mk(1, 32'h0000_5000, 4'hF, 4'hF, 4'b0000, 0,          1, 0, 0));
    tv.push_back(mk(0, 0,             4'h0, 4'hF, 4'b0000, 0,          1, 1, 32'h5000));
    tv.push_back(mk(0, 0,             4'h0, 4'hF, 4'b0000, 0,          1, 0, 32'h5000));
    tv.push_back(mk(1, 32'h0000_7F20, 4'h0, 4'hF, 4'b0000, 0,          1, 0, 32'h5000));
    tv.push_back(mk(1, 32'h9999_0000, 4'h0, 4'hF, 4'b0000, 0,          1, 0, 32'h5000));
    tv.push_back(mk(0, 0,             4'h0, 4'hF, 4'b0000, 0,          1, 0, 32'h5000));
    tv.push_back(mk(1, 32'h0000_2FFF, 4'h1, 4'hF, 4'b0000, 0,          1, 0, 32'h5000));
    tv.push_back(mk(1, 32'h0000_3000, 4'hF, 4'hF, 4'b0001, 32'h2FFF,   1, 0, 32'h5000));
    tv.push_back(mk(1, 32'h0000_7F0B, 4'hF, 4'hF, 4'b0000, 0,          1, 1, 32'h3000));
    tv.push_back(mk(1, 32'h0000_7F0C, 4'hF, 4'hF, 4'b0010, 32'hB,      1, 0, 32'h3000));
    tv.push_back(mk(1, 32'h0000_7F23, 4'hF, 4'hF, 4'b0000, 0,          1, 1, 32'h7F0C));
    tv.push_back(mk(1, 32'h0000_7F24, 4'hF, 4'hF, 4'b1000, 32'h3,      1, 0, 32'h7F0C));
    tv.push_back(mk(0, 0,             4'h0, 4'hF, 4'b0000, 0,          1, 1, 32'h7F24));
    tv.push_back(mk(1, 32'h0000_7F10, 4'hF, 4'hF, 4'b0000, 0,          1, 0, 32'h7F24));
    tv.push_back(mk(1, 32'h0000_7F00, 4'h0, 4'hF, 4'b0100, 0,          1, 0, 32'h7F24));
    tv.push_back(mk(0, 0,             4'h0, 4'hF, 4'b0000, 0,          1, 0, 32'h7F24));

    // Reset state.
    req_valid = 1'b1;
    #3;
    chk("rst req_ready", 32'(req_ready), 0);
    chk("rst slot_wen", 32'(slot_wen), 0);
    chk("rst slot_off", 32'(slot_off), 0);
    chk("rst slot_wdata", slot_wdata, 0);
    chk("rst slot_be", 32'(slot_be), 0);
    chk("rst err_valid", 32'(err_valid), 0);
    chk("rst err_addr", err_addr, 0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (tv[i]) begin
      req_valid = tv[i].valid; req_addr = tv[i].addr; req_wdata = tv[i].wdata;
      req_be = tv[i].be; slot_ready = tv[i].ready;
      @(negedge clk);
      chk($sformatf("row%0d slot_wen", i), 32'(slot_wen), 32'(tv[i].exp_wen));
      chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(tv[i].exp_rdy));
      chk($sformatf("row%0d err_valid", i), 32'(err_valid), 32'(tv[i].exp_err));
      chk($sformatf("row%0d err_addr", i), err_addr, tv[i].exp_eaddr);
      if (tv[i].exp_wen != 4'd0)
        chk($sformatf("row%0d slot_off", i), 32'(slot_off), tv[i].exp_off);
      @(posedge clk); #1;
    end

    // Reset during a timer1 HOLD must drop the strobe without waiting for an edge.
    req_valid = 1'b1; req_addr = 32'h0000_7F18; req_be = 4'hF; slot_ready = 4'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("hold slot_wen", 32'(slot_wen), 32'h4);
    chk("hold slot_off", 32'(slot_off), 32'h8);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async slot_wen", 32'(slot_wen), 0);
    chk("async req_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post-rst req_ready", 32'(req_ready), 1);
    chk("post-rst slot_wen", 32'(slot_wen), 0);
    chk("post-rst slot_be", 32'(slot_be), 0);
    chk("post-rst err_addr", err_addr, 0);
    @(posedge clk); #1;

    // Random traffic against the transaction-level model.
    pv = 0; ps = 0; poff = '0; pdata = '0; pbe = '0; eflag = 0; eaddr = '0;
    for (int c = 0; c < 400; c++) begin
      int          cat;
      bit          rdy_m;
      bit          nerr;
      int          hit_slot;
      cat = $urandom_range(0, 5);
      case (cat)
        0: req_addr = $urandom_range(0, 32'h2FFF);
        1: req_addr = 32'h7F00 + $urandom_range(0, 11);
        2: req_addr = 32'h7F10 + $urandom_range(0, 11);
        3: req_addr = 32'h7F20 + $urandom_range(0, 3);
        4: req_addr = miss_list[$urandom_range(0, 5)];
        default: req_addr = $urandom;
      endcase
      req_valid  = ($urandom_range(0, 3) != 0);
      req_wdata  = $urandom;
      req_be     = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      slot_ready = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      @(negedge clk);
      rdy_m = !pv || slot_ready[ps];
      chk($sformatf("rnd%0d slot_wen", c), 32'(slot_wen), pv ? (32'd1 << ps) : 32'd0);
      chk($sformatf("rnd%0d req_ready", c), 32'(req_ready), 32'(rdy_m));
      chk($sformatf("rnd%0d err_valid", c), 32'(err_valid), 32'(eflag));
      chk($sformatf("rnd%0d err_addr", c), err_addr, eaddr);
      if (pv) begin
        chk($sformatf("rnd%0d slot_off", c), 32'(slot_off), poff);
        chk($sformatf("rnd%0d slot_wdata", c), slot_wdata, pdata);
        chk($sformatf("rnd%0d slot_be", c), 32'(slot_be), 32'(pbe));
      end
      // Advance the model across the coming edge.
      nerr = 0;
      if (pv && slot_ready[ps]) pv = 0;
      if (req_valid && rdy_m && req_be != 4'h0) begin
        hit_slot = -1;
        for (int s = 0; s < 4; s++)
          if (req_addr >= map_lo[s] && req_addr <= map_hi[s]) hit_slot = s;
        if (hit_slot >= 0) begin
          pv = 1; ps = hit_slot;
          poff = (req_addr - map_lo[hit_slot]) & 32'h3FFF;
          pdata = req_wdata; pbe = req_be;
        end else begin
          nerr = 1; eaddr = req_addr;
        end
      end
      eflag = nerr;
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
